// File: rtl/acp_pkg.sv
// rtl/acp_pkg.sv - shared audio channel processor defaults and helpers
package acp_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_VOL_W  = 4;
  localparam int DEF_PWM_W  = 8;
  localparam int SLEW_STEP  = 16;

  // Width of a channel index; kept at least 1 so single-channel blocks still get a port.
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/acp_pwm_mod.sv
// rtl/acp_pwm_mod.sv - free-running PWM modulator with once-per-period level latch
// ACP_MIXER_SLEW_EN limits each latch step to SLEW_STEP.
module acp_pwm_mod
  import acp_pkg::*;
#(
  parameter int PWM_W = DEF_PWM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PWM_W-1:0] target,
  output logic             pwm_out,
  output logic             sample_strobe,
  output logic [PWM_W-1:0] level_out
);

  localparam logic [PWM_W-1:0] CNT_MAX = '1;

  logic [PWM_W-1:0] cnt;
  logic [PWM_W-1:0] level_q;
  logic [PWM_W-1:0] level_next;
  logic             latch;

  assign latch = (cnt == CNT_MAX);

`ifdef ACP_MIXER_SLEW_EN
  localparam logic [PWM_W-1:0] STEP = PWM_W'(SLEW_STEP);

  // Differences are formed before comparing so the step never wraps past the rails.
  always_comb begin
    level_next = target;
    if (target > level_q) begin
      if (target - level_q > STEP) level_next = level_q + STEP;
    end else if (level_q - target > STEP) begin
      level_next = level_q - STEP;
    end
  end
`else
  always_comb begin
    level_next = target;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      level_q       <= '0;
      sample_strobe <= 1'b0;
      pwm_out       <= 1'b0;
    end else begin
      cnt           <= cnt + PWM_W'(1);
      sample_strobe <= latch;
      if (latch) level_q <= level_next;
      pwm_out       <= (cnt < level_q);
    end
  end

  assign level_out = level_q;

endmodule

// File: rtl/acp_mixer_pwm.sv
// rtl/acp_mixer_pwm.sv - volume-weighted channel mixer driving the PWM audio pin
// ACP_MIXER_SLEW_EN enables level slewing inside acp_pwm_mod.
module acp_mixer_pwm
  import acp_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int VOL_W  = DEF_VOL_W,
  parameter int PWM_W  = DEF_PWM_W
) (
  input  logic                        clk50mhz,
  input  logic                        rst,
  input  logic [NUM_CH-1:0]           wave_in,
  input  logic                        vol_wr_en,
  input  logic [ch_idx_w(NUM_CH)-1:0] vol_wr_ch,
  input  logic [VOL_W-1:0]            vol_wr_data,
  input  logic                        mute,
  output logic                        pwm_out,
  output logic                        sample_strobe,
  output logic [PWM_W-1:0]            level_out
);

  localparam int SUM_W = VOL_W + ch_idx_w(NUM_CH);
  localparam int SHIFT = PWM_W - SUM_W;

  logic [NUM_CH-1:0] wave_meta;
  logic [NUM_CH-1:0] wave_sync;
  logic [VOL_W-1:0]  vol [NUM_CH];
  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  sum_next;
  logic [PWM_W-1:0]  target;

  always_comb begin
    sum_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wave_sync[i]) sum_next = sum_next + SUM_W'(vol[i]);
    end
  end

  always_ff @(posedge clk50mhz or posedge rst) begin
    if (rst) begin
      wave_meta <= '0;
      wave_sync <= '0;
      sum       <= '0;
      for (int i = 0; i < NUM_CH; i++) vol[i] <= '0;
    end else begin
      wave_meta <= wave_in;
      wave_sync <= wave_meta;
      sum       <= sum_next;
      if (vol_wr_en) vol[vol_wr_ch] <= vol_wr_data;
    end
  end

  // Scale the mix so full volume on every channel lands near the top of the PWM range.
  assign target = mute ? '0 : (PWM_W'(sum) << SHIFT);

  acp_pwm_mod #(
    .PWM_W(PWM_W)
  ) u_pwm (
    .clk          (clk50mhz),
    .rst          (rst),
    .target       (target),
    .pwm_out      (pwm_out),
    .sample_strobe(sample_strobe),
    .level_out    (level_out)
  );

endmodule

// File: tb/tb_acp_mixer_pwm.sv
// tb/tb_acp_mixer_pwm.sv - randomized self-checking bench for acp_mixer_pwm
module tb_acp_mixer_pwm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] wave_in = '0;
  logic       vol_wr_en = 1'b0;
  logic [1:0] vol_wr_ch = '0;
  logic [3:0] vol_wr_data = '0;
  logic       mute = 1'b0;
  logic       pwm_out;
  logic       sample_strobe;
  logic [7:0] level_out;

  int n_checks = 0;
  int n_pass = 0;

  int         m_vol [4];
  logic [3:0] m_wave;
  logic       m_mute;
  int         ref_level;
  int         want_vol [4];
  logic [3:0] want_wave;
  logic       want_mute;
  logic [1:0] lat_ch;
  logic [3:0] lat_data;
`ifdef ACP_MIXER_SLEW_EN
  localparam int MUTE_PERIODS = 15;
`else
  localparam int MUTE_PERIODS = 1;
`endif

  always #5 clk = ~clk;

  acp_mixer_pwm dut (
    .clk50mhz     (clk),
    .rst          (rst),
    .wave_in      (wave_in),
    .vol_wr_en    (vol_wr_en),
    .vol_wr_ch    (vol_wr_ch),
    .vol_wr_data  (vol_wr_data),
    .mute         (mute),
    .pwm_out      (pwm_out),
    .sample_strobe(sample_strobe),
    .level_out    (level_out)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Mix of 4 channels x 4-bit volume spans 0..60; the 8-bit PWM range needs x4.
  function automatic int model_target();
    int s = 0;
    for (int i = 0; i < 4; i++) if (m_wave[i]) s += m_vol[i];
    return m_mute ? 0 : s * 4;
  endfunction

  task automatic model_latch();
    int t = model_target();
`ifdef ACP_MIXER_SLEW_EN
    if (t > ref_level) ref_level = (t - ref_level > 16) ? ref_level + 16 : t;
    else ref_level = (ref_level - t > 16) ? ref_level - 16 : t;
`else
    ref_level = t;
`endif
  endtask

  task automatic apply_changes();
    for (int i = 0; i < 4; i++) begin
      if (want_vol[i] != m_vol[i]) begin
        vol_wr_en = 1'b1; vol_wr_ch = 2'(i); vol_wr_data = 4'(want_vol[i]);
        m_vol[i] = want_vol[i];
        @(negedge clk);
      end
    end
    vol_wr_en = 1'b0;
    wave_in = want_wave; m_wave = want_wave;
    mute = want_mute;    m_mute = want_mute;
  endtask

  task automatic measure(output int highs, output bit contig, output int stray);
    bit seen_low = 0;
    highs = 0; contig = 1; stray = 0;
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      if (pwm_out) begin
        highs++;
        if (seen_low) contig = 0;
      end else seen_low = 1;
      if (k < 256 && sample_strobe) stray++;
    end
  endtask

  // Starts and ends on a strobe cycle; checks the period just played and the new level.
  task automatic run_period(input string tag, input bit wr_latch, input bit glitch);
    int highs, stray, prev;
    bit contig;
    prev = ref_level;
    fork
      begin
        if (wr_latch) begin
          repeat (255) @(negedge clk);
          vol_wr_en = 1'b1; vol_wr_ch = lat_ch; vol_wr_data = lat_data;
          @(negedge clk);
          vol_wr_en = 1'b0;
        end else begin
          apply_changes();
          if (glitch) begin
            repeat (40) @(negedge clk);
            mute = !want_mute;
            repeat (20) @(negedge clk);
            mute = want_mute;
          end
        end
      end
      measure(highs, contig, stray);
    join
    model_latch();
    check({tag, ".high_clocks"}, highs, prev);
    check({tag, ".contiguous"}, int'(contig), 1);
    check({tag, ".stray_strobe"}, stray, 0);
    check({tag, ".strobe"}, int'(sample_strobe), 1);
    check({tag, ".level"}, int'(level_out), ref_level);
  endtask

  task automatic settle(input string tag, output int n);
    n = 0;
    do begin
      run_period($sformatf("%s[%0d]", tag, n), 1'b0, 1'b0);
      n++;
    end while (ref_level != model_target() && n < 20);
    check({tag, ".settled"}, ref_level, model_target());
  endtask

  task automatic wait_first_strobe(input string tag);
    int n = 0;
    bit seen = 0;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      if (sample_strobe) seen = 1;
    end
    check(tag, n, 256);
  endtask

  task automatic set_want(input int v0, input int v1, input int v2, input int v3,
                          input logic [3:0] w, input logic m);
    want_vol[0] = v0; want_vol[1] = v1; want_vol[2] = v2; want_vol[3] = v3;
    want_wave = w; want_mute = m;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 4; i++) begin m_vol[i] = 0; want_vol[i] = 0; end
    m_wave = '0; m_mute = 1'b0; ref_level = 0;
    want_wave = '0; want_mute = 1'b0;
    lat_ch = '0; lat_data = '0;

    repeat (3) @(negedge clk);
    check("reset.pwm_out", int'(pwm_out), 0);
    check("reset.strobe", int'(sample_strobe), 0);
    check("reset.level", int'(level_out), 0);
    rst = 1'b0;
    wait_first_strobe("reset.first_strobe");

    set_want(15, 0, 0, 0, 4'b0001, 1'b0);
    settle("single_ch", n);
    check("single_ch.level60", int'(level_out), 60);

    set_want(15, 15, 15, 15, 4'b1111, 1'b0);
    settle("full_mix", n);
    run_period("full_mix.hold", 1'b0, 1'b0);
    check("full_mix.level240", int'(level_out), 240);

    set_want(15, 15, 15, 15, 4'b0000, 1'b0);
    settle("silent", n);
    run_period("silent.hold", 1'b0, 1'b0);

    set_want(15, 15, 15, 15, 4'b0001, 1'b0);
    settle("latch_wr.pre", n);
    lat_ch = 2'd0; lat_data = 4'd5;
    run_period("latch_wr.same", 1'b1, 1'b0);
    m_vol[0] = 5; want_vol[0] = 5;
    run_period("latch_wr.next", 1'b0, 1'b0);

    set_want(15, 15, 15, 15, 4'b1111, 1'b0);
    settle("mute.pre", n);
    want_mute = 1'b1;
    settle("mute.on", n);
    check("mute.on_periods", n, MUTE_PERIODS);
    want_mute = 1'b0;
    settle("mute.off", n);
    check("mute.off_periods", n, MUTE_PERIODS);

    for (int r = 0; r < 12; r++) begin
      set_want(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
               4'($urandom), ($urandom_range(0, 3) == 0));
      run_period($sformatf("rand%0d", r), 1'b0, 1'($urandom_range(0, 1)));
    end

    set_want(15, 15, 0, 0, 4'b0011, 1'b0);
    settle("mid_reset.pre", n);
    repeat (100) @(negedge clk);
    check("mid_reset.pwm_before", int'(pwm_out), 1);
    #2 rst = 1'b1;
    #1;
    check("mid_reset.pwm_out", int'(pwm_out), 0);
    check("mid_reset.level", int'(level_out), 0);
    check("mid_reset.strobe", int'(sample_strobe), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin m_vol[i] = 0; want_vol[i] = 0; end
    ref_level = 0;
    wait_first_strobe("mid_reset.first_strobe");
    run_period("mid_reset.post", 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/acp_mixer_pwm.md
# acp_mixer_pwm

Downstream output stage of the audio channel processor. Takes the 1-bit `wave_out` of each square channel, applies a per-channel 4-bit volume, and sums the channels into one mix level. The level drives a free-running PWM modulator whose single-bit output goes to the board's RC-filtered audio pin. One mix sample is taken per PWM period, which is 195.3 kHz with the defaults at 50 MHz.

## Interface
- `NUM_CH`, 4: number of channel wave inputs (power of 2, ≥2).
- `VOL_W`, 4: volume register width per channel.
- `PWM_W`, 8: PWM counter width; period = 2^PWM_W clocks; must satisfy PWM_W ≥ VOL_W + log2(NUM_CH).
- `clk50mhz` in 1: system clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `wave_in` in NUM_CH: channel square outputs, bit i = channel i; asynchronous to the PWM period.
- `vol_wr_en` in 1: one-cycle write strobe for a volume register.
- `vol_wr_ch` in log2(NUM_CH): channel index for the write.
- `vol_wr_data` in VOL_W: new volume (0 = silent, max = loudest).
- `mute` in 1: level-sensitive; forces the target level to 0.
- `pwm_out` out 1: PWM audio output, registered.
- `sample_strobe` out 1: one-cycle pulse in the cycle a new level takes effect.
- `level_out` out PWM_W: currently applied level, for debug and bench checking.

## Operation
- `wave_in` passes through a 2-flop synchronizer per bit before use.
- Volume registers `vol[i]`: all reset to 0. On `vol_wr_en`, `vol[vol_wr_ch] <= vol_wr_data`. The new value is used from the next cycle.
- Mix register `sum`: registered every cycle as Σ (sync_wave[i] ? vol[i] : 0). Width is VOL_W + log2(NUM_CH), unsigned, and cannot overflow (max 60 with defaults).
- Target: `mute` ? 0 : `sum` left-shifted by PWM_W − (VOL_W + log2(NUM_CH)). With defaults this is sum×4, max 240.
- PWM counter `cnt` (PWM_W bits): free-running, increments every cycle and wraps 2^PWM_W−1 → 0.
- Level latch: in the cycle `cnt` = 2^PWM_W−1, `level_q` <= target, or the slewed value (see Configuration). `level_out` = `level_q`.
- Output: `pwm_out <= (cnt < level_q)`. Each period has exactly `level_q` high clocks, contiguous from the start of the period.
  - `level_q` = 0 → output constantly low.
  - `level_q` = max target → low for the remaining 2^PWM_W − max clocks.
- Simultaneous volume write and latch cycle: the latch uses the `sum` registered before the write.
- `mute` is sampled only at the latch cycle. Toggling `mute` mid-period has no effect until the next period.
- Reset, whether idle or mid-period: `cnt`, `vol[*]`, `sum`, `level_q`, synchronizers, `pwm_out` and `sample_strobe` all go to 0 immediately. The first period after reset release starts at `cnt` = 0 with level 0.

## Timing
- `wave_in` edge → `sum` updated: 3 clocks (2 sync + 1 register).
- `sum` → applied level: up to one PWM period. The value is taken at the next latch cycle.
- `sample_strobe`: high for exactly one cycle, the cycle `cnt` = 0, once every 2^PWM_W clocks. The first pulse occurs 2^PWM_W clocks after reset release. No pulse occurs at the release cycle itself.
- `pwm_out` lags `cnt` by one cycle. It first reflects a new `level_q` in the cycle after `sample_strobe`.
- Reset values of all outputs: `pwm_out` = 0, `sample_strobe` = 0, `level_out` = 0.

## Configuration
- `ACP_MIXER_SLEW_EN` defined: at each latch, `level_q` moves toward the target by at most 16 per period, in both directions. Mute therefore ramps down and unmute ramps up, avoiding clicks. With defaults, a full 0↔240 swing takes 15 periods.
- `ACP_MIXER_SLEW_EN` undefined: `level_q` = target at every latch, with no slewing.

## Structure
- The shared `acp_pkg` holds the default `PWM_W`, `VOL_W` and `NUM_CH` values and the slew step constant (16). It also holds the channel-index width function, which other channel-processor blocks reuse.
- One sub-module, `acp_pwm_mod`: the counter, latch, slew and comparator. It takes the target level and produces `pwm_out`, `sample_strobe` and `level_out`.
- The synchronizers, volume registers and mix adder stay in the top-level module.

## Test plan
- **Reset:** assert `rst` mid-period with `level_q` = 120 → `pwm_out`, `level_out` and `sample_strobe` are 0 within the same cycle. After release, the first strobe comes 256 clocks later.
- **Single channel:** write `vol[0]` = 15 and hold `wave_in` = 4'b0001 → after the next strobe, `level_out` = 60 and `pwm_out` is high for 60 of 256 clocks.
- **Full mix:** all volumes 15 and `wave_in` = 4'b1111 → `level_out` = 240, `pwm_out` low for exactly 16 clocks per period. With `wave_in` = 0 → `pwm_out` is constantly low.
- **Simultaneous write and latch:** issue a volume write in the latch cycle → the old level applies for that period and the new level applies in the following period.
- **Mute, macro undefined:** assert `mute` at level 240 → `level_out` = 0 at the next strobe.
- **Mute, macro defined:** assert `mute` at level 240 → `level_out` steps 224, 208, … and reaches 0 after 15 strobes. Releasing `mute` ramps back up symmetrically.
